// File: rtl/log_to_linear_shift_if.sv
// rtl/log_to_linear_shift_if.sv - handshake bundle for the log-to-linear decoder
interface log_to_linear_shift_if #(
    parameter int BITS     = 18,
    parameter int OUT_BITS = 32
);
    logic                in_valid;
    logic                in_ready;
    logic [BITS-1:0]     L_in;
    logic                S_in;
    logic                out_valid;
    logic                out_ready;
    logic [OUT_BITS-1:0] lin_out;
    logic                sign_out;
    logic                sat_out;

    modport master (
        output in_valid, L_in, S_in, out_ready,
        input  in_ready, out_valid, lin_out, sign_out, sat_out
    );

    modport slave (
        input  in_valid, L_in, S_in, out_ready,
        output in_ready, out_valid, lin_out, sign_out, sat_out
    );
endinterface

// File: rtl/log_to_linear_shift.sv
// rtl/log_to_linear_shift.sv - iterative Mitchell antilog, one shift per clock
// Optional round-half-up on right shifts: LOG_TO_LINEAR_ROUND_EN
module log_to_linear_shift #(
    parameter int BITS     = 18,
    parameter int FRAC     = 9,
    parameter int OUT_BITS = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    log_to_linear_shift_if.slave  bus
);
    localparam int KW    = BITS - FRAC;
    localparam int CW    = $clog2(OUT_BITS + 1);
    localparam int MAX_K = OUT_BITS - FRAC - 1;
    localparam int MIN_K = -(FRAC + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t              state_q, state_d;
    logic [OUT_BITS-1:0] work_q, work_d;
    logic [OUT_BITS-1:0] lin_q, lin_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                right_q, right_d;
    logic                sign_q, sign_d;
    logic                sat_q, sat_d;
    logic                valid_q, valid_d;

    logic signed [31:0]  k_ext;
    logic [31:0]         abs_k;
    logic [OUT_BITS-1:0] mant;
    logic [OUT_BITS-1:0] src;
    logic [OUT_BITS-1:0] step;
    logic [OUT_BITS-1:0] lin_fin;
    logic                src_right;

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        lin_d   = lin_q;
        cnt_d   = cnt_q;
        right_d = right_q;
        sign_d  = sign_q;
        sat_d   = sat_q;
        valid_d = valid_q;

        k_ext = {{(32-KW){bus.L_in[BITS-1]}}, bus.L_in[BITS-1:FRAC]};
        abs_k = k_ext[31] ? 32'(-k_ext) : 32'(k_ext);
        mant  = {{(OUT_BITS-FRAC-1){1'b0}}, 1'b1, bus.L_in[FRAC-1:0]};

        // The first shift happens on the accept edge so latency equals |k|.
        src       = (state_q == IDLE) ? mant : work_q;
        src_right = (state_q == IDLE) ? k_ext[31] : right_q;
        step      = src_right ? (src >> 1) : (src << 1);
`ifdef LOG_TO_LINEAR_ROUND_EN
        lin_fin   = step + {{(OUT_BITS-1){1'b0}}, src_right & src[0]};
`else
        lin_fin   = step;
`endif

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    sign_d  = bus.S_in;
                    sat_d   = 1'b0;
                    right_d = k_ext[31];
                    if (k_ext > MAX_K) begin
                        lin_d   = '1;
                        sat_d   = 1'b1;
                        valid_d = 1'b1;
                        state_d = DONE;
                    end else if (k_ext < MIN_K) begin
                        lin_d   = '0;
                        valid_d = 1'b1;
                        state_d = DONE;
                    end else if (k_ext == 0) begin
                        lin_d   = mant;
                        valid_d = 1'b1;
                        state_d = DONE;
                    end else if (abs_k == 32'd1) begin
                        lin_d   = lin_fin;
                        valid_d = 1'b1;
                        state_d = DONE;
                    end else begin
                        work_d  = step;
                        cnt_d   = CW'(abs_k - 32'd1);
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                work_d = step;
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    lin_d   = lin_fin;
                    valid_d = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            work_q  <= '0;
            lin_q   <= '0;
            cnt_q   <= '0;
            right_q <= 1'b0;
            sign_q  <= 1'b0;
            sat_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            lin_q   <= lin_d;
            cnt_q   <= cnt_d;
            right_q <= right_d;
            sign_q  <= sign_d;
            sat_q   <= sat_d;
            valid_q <= valid_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = valid_q;
    assign bus.lin_out   = lin_q;
    assign bus.sign_out  = sign_q;
    assign bus.sat_out   = sat_q;
endmodule

// File: tb/tb_log_to_linear_shift.sv
// tb/tb_log_to_linear_shift.sv - self-checking bench for log_to_linear_shift
module tb_log_to_linear_shift;
    localparam int BITS     = 18;
    localparam int FRAC     = 9;
    localparam int OUT_BITS = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    log_to_linear_shift_if #(.BITS(BITS), .OUT_BITS(OUT_BITS)) bus ();

    log_to_linear_shift #(.BITS(BITS), .FRAC(FRAC), .OUT_BITS(OUT_BITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int passed = 0;
    int total  = 0;

    logic [OUT_BITS-1:0] e_lin;
    logic                e_sat;
    int                  e_lat;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic signed [BITS-1:0] l);
        int li, fr, k, m, n;
        li = int'(l);
        fr = li & ((1 << FRAC) - 1);
        k  = (li - fr) / (1 << FRAC);
        m  = (1 << FRAC) + fr;
        e_sat = 1'b0;
        e_lat = 1;
        if (k > OUT_BITS - FRAC - 1) begin
            e_lin = '1;
            e_sat = 1'b1;
        end else if (-k > FRAC + 1) begin
            e_lin = '0;
        end else if (k >= 0) begin
            e_lin = 32'(longint'(m) << k);
            e_lat = (k == 0) ? 1 : k;
        end else begin
            n = -k;
`ifdef LOG_TO_LINEAR_ROUND_EN
            e_lin = 32'((m + (1 << (n - 1))) >> n);
`else
            e_lin = 32'(m >> n);
`endif
            e_lat = n;
        end
    endtask

    task automatic run(input logic signed [BITS-1:0] l, input logic s, input int hold);
        int lat;
        model(l);
        @(negedge clk);
        check("in_ready_idle", 64'(bus.in_ready), 64'(1'b1));
        bus.in_valid = 1'b1;
        bus.L_in     = l;
        bus.S_in     = s;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.L_in     = 18'($urandom);
        bus.S_in     = ~s;
        lat = 1;
        while (bus.out_valid !== 1'b1 && lat < 64) begin
            check("in_ready_busy", 64'(bus.in_ready), 64'(1'b0));
            @(negedge clk);
            lat++;
        end
        check("out_valid", 64'(bus.out_valid), 64'(1'b1));
        check("latency", 64'(lat), 64'(e_lat));
        check("lin_out", 64'(bus.lin_out), 64'(e_lin));
        check("sat_out", 64'(bus.sat_out), 64'(e_sat));
        check("sign_out", 64'(bus.sign_out), 64'(s));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", 64'(bus.out_valid), 64'(1'b1));
            check("hold_lin", 64'(bus.lin_out), 64'(e_lin));
            check("hold_in_ready", 64'(bus.in_ready), 64'(1'b0));
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("consumed_valid", 64'(bus.out_valid), 64'(1'b0));
        check("consumed_in_ready", 64'(bus.in_ready), 64'(1'b1));
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.L_in      = '0;
        bus.S_in      = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        check("rst_valid", 64'(bus.out_valid), 64'(1'b0));
        check("rst_lin", 64'(bus.lin_out), 64'(32'd0));
        check("rst_sign", 64'(bus.sign_out), 64'(1'b0));
        check("rst_sat", 64'(bus.sat_out), 64'(1'b0));
        check("rst_in_ready", 64'(bus.in_ready), 64'(1'b1));
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run(18'sd0, 1'b0, 0);
        check("direct_zero", 64'(bus.lin_out), 64'(32'd512));
        run(18'sd1536, 1'b0, 0);
        check("direct_k3", 64'(bus.lin_out), 64'(32'd4096));
        run(-18'sd256, 1'b1, 0);
        check("direct_km1", 64'(bus.lin_out), 64'(32'd384));
        run(18'sd256, 1'b0, 0);
        check("direct_k0", 64'(bus.lin_out), 64'(32'd768));
        run(-18'sd511, 1'b0, 0);
`ifdef LOG_TO_LINEAR_ROUND_EN
        check("direct_round", 64'(bus.lin_out), 64'(32'd257));
`else
        check("direct_trunc", 64'(bus.lin_out), 64'(32'd256));
`endif
        run(18'sd11264, 1'b0, 0);
        check("direct_k22", 64'(bus.lin_out), 64'(32'h8000_0000));
        run(18'sd11776, 1'b1, 0);
        check("direct_k23_sat", 64'(bus.sat_out), 64'(1'b1));
        run(-18'sd5632, 1'b1, 0);
        check("direct_km11", 64'(bus.lin_out), 64'(32'd0));
        run(-18'sd5120, 1'b0, 0);
        run(18'sd7000, 1'b1, 5);

        for (int i = 0; i < 50; i++) begin
            logic signed [BITS-1:0] l;
            int k;
            if (i % 5 == 4) begin
                l = 18'($urandom);
            end else begin
                k = int'($urandom_range(36)) - 12;
                l = 18'(k * 512 + int'($urandom_range(511)));
            end
            run(l, 1'($urandom), int'($urandom_range(3)));
        end

        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.L_in     = 18'sd10240;
        bus.S_in     = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_busy", 64'(bus.in_ready), 64'(1'b0));
        rst = 1'b1;
        #1;
        check("midrst_valid", 64'(bus.out_valid), 64'(1'b0));
        check("midrst_lin", 64'(bus.lin_out), 64'(32'd0));
        check("midrst_sign", 64'(bus.sign_out), 64'(1'b0));
        check("midrst_in_ready", 64'(bus.in_ready), 64'(1'b1));
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            check("post_rst_no_output", 64'(bus.out_valid), 64'(1'b0));
        end
        check("post_rst_in_ready", 64'(bus.in_ready), 64'(1'b1));
        run(-18'sd1024, 1'b0, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/log_to_linear_shift.md
Name: log_to_linear_shift

Overview:
- Iterative decoder from the sign/log number format back to signed-magnitude linear fixed point. It is the reverse end of the log-domain adder datapath.
- Input: log2 magnitude L (two's complement, FRAC fractional bits) plus sign bit.
- Output: Mitchell antilog approximation 2^L ≈ (1 + frac(L)) << floor(L), computed with one shift per clock.
- Sits between the log-domain arithmetic units and any linear-domain consumer. Uses valid/ready handshakes on both sides.

Parameters:
- BITS, 18, width of log input L including its two's-complement sign bit.
- FRAC, 9, fractional bits of L; also the fractional bits of the linear output.
- OUT_BITS, 32, width of the linear output magnitude; must satisfy OUT_BITS >= FRAC+2.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  1  L_in/S_in valid.
- in_ready  output  1  block can accept an input (high only in IDLE).
- L_in  input  BITS  signed log2 magnitude, FRAC fractional bits.
- S_in  input  1  sign of the value (1 = negative).
- out_valid  output  1  result valid, held until consumed.
- out_ready  input  1  consumer accepts result.
- lin_out  output  OUT_BITS  unsigned linear magnitude, FRAC fractional bits.
- sign_out  output  1  registered copy of S_in.
- sat_out  output  1  result saturated (overflow).

Behaviour:
- Reset (async, rst=1) forces the following, regardless of clk:
  - state=IDLE
  - lin_out=0, sign_out=0, sat_out=0, out_valid=0
  - internal shift count=0
- in_ready=1 iff state==IDLE. Reset mid-operation discards the conversion; no output is produced for it.
- Decomposition at the accept cycle (in_valid & in_ready):
  - k = L_in >>> FRAC, signed floor, range -2^(BITS-1-FRAC) .. 2^(BITS-1-FRAC)-1.
  - m = {1'b1, L_in[FRAC-1:0]}, FRAC+1 bits, zero-extended to OUT_BITS into the working register.
  - Register sign.
- Early exits at accept. Next state is DONE; the result is visible 1 cycle after accept.
  - Overflow, k > OUT_BITS-FRAC-1: lin_out = all ones, sat_out=1.
  - Underflow, -k > FRAC+1: lin_out = 0, sat_out=0.
  - k==0: lin_out = m.
- Otherwise next state is SHIFT with count=|k| and direction = sign of k.
- SHIFT, once per cycle:
  - Working register shifts by 1 (left if k>0, logical right if k<0); count decrements.
  - When the post-decrement count reaches 0, go to DONE.
  - Total latency from accept to out_valid = |k| cycles.
  - Left shifts never lose set bits, guaranteed by the overflow bound.
- DONE:
  - out_valid=1; lin_out/sign_out/sat_out stable.
  - On out_ready=1 go to IDLE next cycle with out_valid=0. in_ready rises in that IDLE cycle, so there is no same-cycle accept in DONE.
- out_ready is ignored outside DONE. in_valid is ignored outside IDLE; the input is not sampled.
- Sign never affects magnitude. sign_out passes through even for zero results.

Optional Feature:
- Macro: LOG_TO_LINEAR_ROUND_EN.
- Defined:
  - A guard register captures the last bit shifted out on right shifts; a sticky bit is not required.
  - On entry to DONE from a right-shift path, lin_out = shifted value + guard (round half up).
  - Rounding adds 0 extra cycles; the add is on the DONE-entry edge.
  - Underflow early exit stays 0.
- Undefined: right shifts truncate. Guard logic is absent.

Test Plan:
- L_in=0, S_in=0 -> out_valid 1 cycle after accept, lin_out=512, sign_out=0, sat_out=0.
- L_in=1536 (k=3) -> lin_out=4096, out_valid exactly 3 cycles after accept; in_ready=0 throughout.
- L_in=-256 (k=-1, frac=256), S_in=1 -> lin_out=384, sign_out=1; L_in=256 -> lin_out=768.
- L_in=-511:
  - without ROUND_EN -> lin_out=256.
  - with LOG_TO_LINEAR_ROUND_EN -> lin_out=257.
- Boundary values:
  - L_in=11264 (k=22) -> lin_out=2^31, no saturation.
  - L_in=11776 (k=23) -> lin_out=32'hFFFFFFFF, sat_out=1, 1-cycle latency.
  - L_in=-5632 (k=-11) -> lin_out=0.
- Backpressure and reset:
  - Hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0.
  - Assert rst during SHIFT -> immediate out_valid=0, lin_out=0, state IDLE, in_ready=1 after release.
